wavelet_sample_buffer: RTL and testbench
========================================

Name: wavelet_sample_buffer

Overview:
- Receiving end of the db_wavelet output interface: consumes `output_abs_data`/`write_enable` and buffers one capture frame of wavelet magnitude samples in a synchronous FIFO.
- The RISC-V side (or a later segmentation stage) drains the buffer through a simple read-request port.
- A small capture FSM arms on a start pulse and counts exactly FRAME_LEN input strobes, so the downstream sees whole, aligned frames.

Parameters:
- DATA_WIDTH, 32, sample width; matches the db_wavelet output width.
- DEPTH, 64, FIFO entries; must be a power of two and >= 2.
- FRAME_LEN, 48, input strobes per capture frame; must be >= 1.
- AW, $clog2(DEPTH), derived pointer width; not overridable.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms a frame capture.
- input_data  in  DATA_WIDTH  sample from db_wavelet `output_abs_data`.
- write_enable  in  1  sample strobe from db_wavelet.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid this cycle (single-cycle pulse).
- count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- busy  out  1  FSM is in CAPTURE.
- frame_done  out  1  sticky; frame capture completed.
- overflow  out  1  sticky; at least one sample was dropped because the FIFO was full.

Behaviour:
- Reset (RST=1 at a clock edge):
  - FSM goes to IDLE; read/write pointers and count cleared.
  - rd_data=0, rd_valid=0, busy=0, frame_done=0, overflow=0, empty=1, full=0.
  - Reset asserted mid-capture discards the FIFO contents and the frame.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE --start--> CAPTURE. Clears the sample counter, frame_done and overflow.
  - CAPTURE: each cycle with write_enable=1 increments the sample counter. When the counter is FRAME_LEN-1 and write_enable=1, go to DONE and set frame_done on the same edge.
  - DONE --start--> CAPTURE. Clears the counter, frame_done and overflow; the FIFO keeps its contents.
  - start while in CAPTURE is ignored.
- Write acceptance: write_enable is honoured only in CAPTURE. Strobes in IDLE or DONE are dropped silently and do not set overflow.
- Write while full (and no same-cycle read): the sample is dropped and overflow is set. The sample counter still increments, so a frame is timed in input strobes, not stored samples.
- Read: rd_en=1 with empty=0 pops the head. rd_data updates and rd_valid=1 on the next cycle (1-cycle read latency).
  - rd_en while empty is ignored: rd_valid=0 and rd_data holds its value.
  - rd_data holds between reads.
- Simultaneous read and write in the same cycle:
  - Not empty: both happen, count is unchanged.
  - Full: the read frees a slot, the write is accepted, and overflow is not set.
  - Empty: the write is accepted and the read is ignored (no fall-through).
- Pointers wrap modulo DEPTH. count/empty/full are registered and consistent with the pointers on every cycle.
- The FIFO memory is inferable as distributed/block RAM: no reset on the storage array.

Decomposition:
- Shared package hss_pkg holds:
  - FSM state typedef (IDLE/CAPTURE/DONE) and the localparam state encodings.
  - SAMPLE_W=32, shared with db_wavelet.
- One natural sub-module: sync_fifo (parameters DATA_WIDTH, DEPTH; ports CLK, RST, wr_en, wr_data, rd_en, rd_data, rd_valid, count, empty, full).
- The top level holds the capture FSM, the frame counter and the sticky flags.

Test Plan:
1. Reset, then write_enable pulses with no start -> count stays 0, empty=1, overflow=0.
2. DEPTH=64, FRAME_LEN=4: start, then 6 strobes with data 0x0000_0011..0x0000_0016 -> frame_done=1 after the 4th strobe, busy=0, count=4; reading 4 times returns 0x11..0x14 in order, each with rd_valid one cycle after rd_en.
3. DEPTH=4, FRAME_LEN=6: start plus 6 strobes, no reads -> count=4, full=1, overflow=1, frame_done=1; reads return only the first 4 samples.
4. Full FIFO, rd_en and write_enable in the same cycle while in CAPTURE -> count stays 4, overflow stays 0, and the new sample appears after the 3 older ones.
5. rd_en while empty -> rd_valid=0 and rd_data unchanged. RST asserted mid-capture (after 2 of 4 strobes) -> state IDLE, count=0, all flags cleared on the next cycle.
6. Pointer wrap: DEPTH=4, FRAME_LEN=10 with interleaved reads keeping count ≤ 3 -> all 10 samples read back in order and overflow=0.

Source files
------------

// File: rtl/wavelet_sample_buffer_pkg.sv
// rtl/wavelet_sample_buffer_pkg.sv - shared types and constants for the wavelet capture path
package hss_pkg;

   // Sample width produced by db_wavelet on output_abs_data
   localparam int SAMPLE_W = 32;

   // Capture FSM encodings
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      CAPTURE = ST_CAPTURE,
      DONE    = ST_DONE
   } cap_state_t;

endpackage

// File: rtl/wavelet_sample_buffer_if.sv
// rtl/wavelet_sample_buffer_if.sv - sample input, read port and status bundle of the capture buffer
interface wavelet_sample_buffer_if
   import hss_pkg::*;
#(
   parameter int DATA_WIDTH = SAMPLE_W,
   parameter int DEPTH      = 64
);
   localparam int AW = $clog2(DEPTH);

   logic                  start;
   logic [DATA_WIDTH-1:0] input_data;
   logic                  write_enable;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic [AW:0]           count;
   logic                  empty;
   logic                  full;
   logic                  busy;
   logic                  frame_done;
   logic                  overflow;

   // Producer/consumer side: drives samples, start and read requests
   modport master (
      output start, input_data, write_enable, rd_en,
      input  rd_data, rd_valid, count, empty, full, busy, frame_done, overflow
   );

   // Buffer side
   modport slave (
      input  start, input_data, write_enable, rd_en,
      output rd_data, rd_valid, count, empty, full, busy, frame_done, overflow
   );

endinterface

// File: rtl/wavelet_sample_buffer_sync_fifo.sv
// rtl/wavelet_sample_buffer_sync_fifo.sv - single-clock FIFO with registered read data and occupancy
module sync_fifo
   import hss_pkg::*;
#(
   parameter  int DATA_WIDTH = SAMPLE_W,
   parameter  int DEPTH      = 64,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [AW:0]           count,
   output logic                  empty,
   output logic                  full
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_rd;
   logic                  do_wr;
   logic [AW:0]           count_next;

   // A read on an empty FIFO is ignored; a write into a full FIFO only
   // lands when a same-cycle read frees the head slot.
   always_comb begin
      do_rd      = rd_en && !empty;
      do_wr      = wr_en && (!full || do_rd);
      count_next = count;
      case ({do_wr, do_rd})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Storage array, intentionally without reset so it maps onto RAM
   always_ff @(posedge CLK) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and registered occupancy flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == FULL_COUNT);
      end
   end

   // Read data register: one cycle latency, holds between pops
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= do_rd;
         if (do_rd) begin
            rd_data <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: rtl/wavelet_sample_buffer.sv
// rtl/wavelet_sample_buffer.sv - frame capture FSM and sample buffer behind db_wavelet
module wavelet_sample_buffer
   import hss_pkg::*;
#(
   parameter  int DATA_WIDTH = SAMPLE_W,
   parameter  int DEPTH      = 64,
   parameter  int FRAME_LEN  = 48,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                    CLK,
   input  logic                    RST,
   wavelet_sample_buffer_if.slave  bus
);

   // Wide enough to hold FRAME_LEN-1 for any FRAME_LEN >= 1
   localparam int             CW   = $clog2(FRAME_LEN) + 1;
   localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);

   cap_state_t    state;
   cap_state_t    state_next;
   logic          arm;
   logic          frame_end;
   logic          capturing;
   logic          fifo_wr;
   logic          drop;
   logic [CW-1:0] sample_cnt;
   logic          done_flag;
   logic          ovf_flag;

   // Capture state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: start arms from IDLE or DONE, the last strobe of a frame ends capture
   always_comb begin
      state_next = state;
      arm        = 1'b0;
      frame_end  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_next = CAPTURE;
               arm        = 1'b1;
            end
         end
         CAPTURE: begin
            if (bus.write_enable && (sample_cnt == LAST)) begin
               state_next = DONE;
               frame_end  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes outside CAPTURE never reach the FIFO. A full FIFO with no
   // same-cycle read loses the sample; full implies non-empty, so rd_en
   // alone tells us a slot is being freed.
   always_comb begin
      capturing = (state == CAPTURE);
      fifo_wr   = capturing && bus.write_enable;
      drop      = fifo_wr && bus.full && !bus.rd_en;
   end

   // Frame timing counts input strobes, including dropped ones
   always_ff @(posedge CLK) begin
      if (RST) begin
         sample_cnt <= '0;
      end else if (arm) begin
         sample_cnt <= '0;
      end else if (fifo_wr) begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   // Sticky status, cleared whenever a new frame is armed
   always_ff @(posedge CLK) begin
      if (RST) begin
         done_flag <= 1'b0;
         ovf_flag  <= 1'b0;
      end else if (arm) begin
         done_flag <= 1'b0;
         ovf_flag  <= 1'b0;
      end else begin
         if (frame_end) done_flag <= 1'b1;
         if (drop)      ovf_flag  <= 1'b1;
      end
   end

   assign bus.busy       = capturing;
   assign bus.frame_done = done_flag;
   assign bus.overflow   = ovf_flag;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .wr_en    (fifo_wr),
      .wr_data  (bus.input_data),
      .rd_en    (bus.rd_en),
      .rd_data  (bus.rd_data),
      .rd_valid (bus.rd_valid),
      .count    (bus.count),
      .empty    (bus.empty),
      .full     (bus.full)
   );

endmodule

// File: tb/tb_wavelet_sample_buffer.sv
// tb/tb_wavelet_sample_buffer.sv - randomized model-checked bench for wavelet_sample_buffer
module tb_wavelet_sample_buffer;

   localparam int DW        = 32;
   localparam int DEPTH     = 4;
   localparam int FRAME_LEN = 6;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wavelet_sample_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   wavelet_sample_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .FRAME_LEN  (FRAME_LEN)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: a queue holding the buffered frame plus a few flags
   logic [DW-1:0] q [$];
   bit            m_cap;
   bit            m_done;
   bit            m_ovf;
   bit            m_valid;
   int            m_strobes;
   logic [DW-1:0] m_rd_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_update(input bit s, input bit we, input logic [DW-1:0] d,
                               input bit rd, input bit r);
      bit pop;
      if (r) begin
         q.delete();
         m_cap     = 0;
         m_done    = 0;
         m_ovf     = 0;
         m_valid   = 0;
         m_strobes = 0;
         m_rd_data = '0;
      end else begin
         pop     = rd && (q.size() > 0);
         m_valid = pop;
         if (pop) m_rd_data = q.pop_front();
         if (m_cap) begin
            if (we) begin
               if (q.size() < DEPTH) q.push_back(d);
               else                  m_ovf = 1;
               m_strobes++;
               if (m_strobes == FRAME_LEN) begin
                  m_cap  = 0;
                  m_done = 1;
               end
            end
         end else if (s) begin
            m_cap     = 1;
            m_strobes = 0;
            m_done    = 0;
            m_ovf     = 0;
         end
      end
   endtask

   task automatic cycle(input bit s, input bit we, input logic [DW-1:0] d,
                        input bit rd, input bit r);
      rst              = r;
      bus.start        = s;
      bus.write_enable = we;
      bus.input_data   = d;
      bus.rd_en        = rd;
      @(posedge clk);
      model_update(s, we, d, rd, r);
      #1;
      chk("rd_valid",   64'(bus.rd_valid),   64'(m_valid));
      chk("rd_data",    64'(bus.rd_data),    64'(m_rd_data));
      chk("count",      64'(bus.count),      64'(q.size()));
      chk("empty",      64'(bus.empty),      64'(q.size() == 0));
      chk("full",       64'(bus.full),       64'(q.size() == DEPTH));
      chk("busy",       64'(bus.busy),       64'(m_cap));
      chk("frame_done", 64'(bus.frame_done), 64'(m_done));
      chk("overflow",   64'(bus.overflow),   64'(m_ovf));
   endtask

   initial begin
      int rd_div;
      // Reset
      cycle(0, 0, '0, 0, 1);
      cycle(0, 0, '0, 0, 1);

      // Strobes with no start are dropped without overflow
      for (int i = 0; i < 5; i++) cycle(0, 1, 32'hA0 + 32'(i), 0, 0);

      // Frame longer than the FIFO: fill, overflow, frame_done
      cycle(1, 0, '0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 32'h11 + 32'(i), 0, 0);
      cycle(0, 1, 32'hDEAD, 0, 0);
      // Drain, then read once more while empty
      for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 0);
      cycle(0, 0, '0, 0, 0);

      // Full FIFO with simultaneous read and write while capturing
      cycle(1, 0, '0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 32'h21 + 32'(i), 0, 0);
      cycle(1, 1, 32'h25, 1, 0);
      cycle(0, 0, '0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 0);

      // Simultaneous read and write on an empty FIFO
      cycle(0, 1, 32'h31, 1, 0);
      cycle(0, 0, '0, 1, 0);

      // Reset mid-capture after 2 strobes
      cycle(1, 0, '0, 0, 0);
      cycle(0, 1, 32'h41, 0, 0);
      cycle(0, 1, 32'h42, 0, 0);
      cycle(0, 0, '0, 0, 1);
      cycle(0, 0, '0, 0, 0);

      // Pointer wrap with interleaved reads keeping occupancy low
      cycle(1, 0, '0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 1, $urandom, (i % 2) == 1, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1, 0);

      // Randomized traffic with varying read pressure
      for (int i = 0; i < 3000; i++) begin
         rd_div = 1 + (i / 500) % 4;
         cycle(($urandom % 8) == 0,
               ($urandom % 3) != 0,
               $urandom,
               ($urandom % rd_div) == 0,
               ($urandom % 250) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
